count_display_mux: RTL

Downstream display stage for the 16-bit event counter. It consumes the counter's `count` and `tc` outputs and drives a 4-digit, time-multiplexed, common-anode 7-segment display with the count in hexadecimal. The count is snapshotted once per scan frame so all four digits show one consistent value. A terminal-count pulse is stretched into a visible decimal point.

---
 rtl/count_display_mux.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/count_display_mux.sv
// count_display_mux
// Display stage for the 16-bit event counter. Scans four common-anode
// 7-segment digits showing the count in hex. The count is captured once per
// scan frame so every digit of a frame comes from the same value. A one-cycle
// terminal-count pulse is stretched into a decimal point that stays lit on
// digit 0 for one full frame.

module count_display_mux #(
  parameter int SCAN_DIV   = 50000,
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LZ   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] count_in,
  input  logic        tc_in,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  // A one-cycle dwell still needs a one-bit prescaler so the compare is legal.
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

  // Reset image of the output registers: digit 0 selected, showing "0",
  // decimal point dark, expressed in the configured polarity.
  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam logic [6:0] SEG_RST  = ACTIVE_LOW ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [3:0] AN_RST   = ACTIVE_LOW ? 4'b1110 : 4'b0001;
  localparam logic       DP_RST   = ACTIVE_LOW ? 1'b1 : 1'b0;

  logic [PRE_W-1:0] pre;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic             dp_flag;
  logic             tc_sticky;

  logic             tick;
  logic             frame_wrap;
  logic [3:0]       nib;
  logic             blank;
  logic [6:0]       seg_pat;
  logic [3:0]       an_pat;
  logic             dp_pat;

  // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] p;
    p = 7'h00;
    case (h)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  assign tick       = (pre == PRE_MAX);
  assign frame_wrap = tick && (idx == 2'd3);

  // Dwell prescaler: one tick every SCAN_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_W'(1);
    end
  end

  // Digit scan index, advancing once per dwell and wrapping naturally at 3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= 2'd0;
    end else if (tick) begin
      idx <= idx + 2'd1;
    end
  end

  // Frame snapshot of the count and the decimal-point flag; hold freezes both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap    <= 16'h0000;
      dp_flag <= 1'b0;
    end else if (frame_wrap && !hold) begin
      snap    <= count_in;
      dp_flag <= tc_sticky | tc_in;
    end
  end

  // Remember any terminal-count pulse until a loading frame wrap consumes it;
  // a pulse on the wrap edge itself is folded straight into dp_flag instead.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tc_sticky <= 1'b0;
    end else if (frame_wrap && !hold) begin
      tc_sticky <= 1'b0;
    end else if (tc_in) begin
      tc_sticky <= 1'b1;
    end
  end

  // Current nibble, leading-zero decision and active-high output patterns.
  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    case (idx)
      2'd0: begin
        nib   = snap[3:0];
        blank = 1'b0;
      end
      2'd1: begin
        nib   = snap[7:4];
        blank = (snap[15:4] == 12'h000);
      end
      2'd2: begin
        nib   = snap[11:8];
        blank = (snap[15:8] == 8'h00);
      end
      default: begin
        nib   = snap[15:12];
        blank = (snap[15:12] == 4'h0);
      end
    endcase
    seg_pat = (BLANK_LZ && blank) ? 7'h00 : hex7(nib);
    an_pat  = 4'b0001 << idx;
    dp_pat  = (idx == 2'd0) && dp_flag;
  end

  // Output registers with the polarity inversion applied on the way in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_RST;
      an  <= AN_RST;
      dp  <= DP_RST;
    end else begin
      seg <= ACTIVE_LOW ? ~seg_pat : seg_pat;
      an  <= ACTIVE_LOW ? ~an_pat : an_pat;
      dp  <= ACTIVE_LOW ? ~dp_pat : dp_pat;
    end
  end

endmodule
